// File: rtl/phase_address_gen.sv
// Phase accumulator driving a 256-point waveform table address from a divided sample tick.
// A new step is adopted only at the wrap tick, which keeps every waveform period at a single frequency.
module phase_address_gen #(
    parameter int unsigned DIV = 2000,
    parameter int unsigned CW  = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sync_clr,
    input  logic [7:0] f_step,
    output logic [7:0] addr,
    output logic       sample_tick,
    output logic       wrap,
    output logic [7:0] step_active
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;
    logic [7:0]    eff;
    logic [8:0]    sum;

    // A zero active step defers to the live request so that a stalled generator restarts immediately.
    always_comb begin
        tick = en && (cnt == CNT_LAST);
        eff  = (step_active == 8'd0) ? f_step : step_active;
        sum  = {1'b0, addr} + {1'b0, eff};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            addr        <= '0;
            sample_tick <= 1'b0;
            wrap        <= 1'b0;
            step_active <= 8'd1;
        end else if (sync_clr) begin
            cnt         <= '0;
            addr        <= '0;
            sample_tick <= 1'b0;
            wrap        <= 1'b0;
            step_active <= f_step;
        end else if (!en) begin
            cnt         <= '0;
            sample_tick <= 1'b0;
            wrap        <= 1'b0;
            step_active <= f_step;
        end else if (tick) begin
            cnt         <= '0;
            addr        <= sum[7:0];
            sample_tick <= 1'b1;
            wrap        <= sum[8];
            if (sum[8] || (step_active == 8'd0))
                step_active <= f_step;
        end else begin
            cnt         <= cnt + 1'b1;
            sample_tick <= 1'b0;
            wrap        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_phase_address_gen.sv
// Directed bench for phase_address_gen with DIV=4; expected values are worked out by hand per scenario.
module tb_phase_address_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sync_clr = 1'b0;
    logic [7:0] f_step = 8'd1;
    logic [7:0] addr;
    logic       sample_tick;
    logic       wrap;
    logic [7:0] step_active;

    int errors = 0;
    int checks = 0;

    phase_address_gen #(.DIV(4), .CW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sync_clr    (sync_clr),
        .f_step      (f_step),
        .addr        (addr),
        .sample_tick (sample_tick),
        .wrap        (wrap),
        .step_active (step_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until sample_tick is seen; a timeout returns the budget.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_tick && n < 20);
    endtask

    initial begin
        int n;
        int ea;

        // Reset held across several edges
        repeat (3) step();
        check("rst_addr", addr, 0);
        check("rst_tick", sample_tick, 0);
        check("rst_wrap", wrap, 0);
        check("rst_step", step_active, 1);

        rst = 1'b0;
        step();
        en = 1'b1;
        wait_tick(n);
        check("first_tick_latency", n, 4);
        check("first_tick_addr", addr, 1);

        // Full sweep with step 1 up to and through the wrap
        for (int i = 2; i <= 256; i++) begin
            wait_tick(n);
            check("sweep_interval", n, 4);
            check("sweep_addr", addr, i % 256);
            check("sweep_wrap", wrap, (i == 256) ? 1 : 0);
        end
        step();
        check("wrap_one_cycle", wrap, 0);
        check("tick_one_cycle", sample_tick, 0);

        // Asynchronous reset mid-count at addr 0x37
        for (int i = 1; i <= 55; i++) wait_tick(n);
        check("pre_rst_addr", addr, 8'h37);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("async_rst_addr", addr, 0);
        check("async_rst_tick", sample_tick, 0);
        check("async_rst_wrap", wrap, 0);
        check("async_rst_step", step_active, 1);
        step();
        rst = 1'b0;
        wait_tick(n);
        check("post_rst_latency", n, 4);
        check("post_rst_addr", addr, 1);

        // Deferred step change: 20 in use, request 2 at addr 100
        f_step = 8'd20;
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check("clr_addr", addr, 0);
        check("clr_step", step_active, 20);
        for (int k = 1; k <= 5; k++) begin
            wait_tick(n);
            check("step20_addr", addr, 20 * k);
        end
        f_step = 8'd2;
        for (int k = 6; k <= 12; k++) begin
            wait_tick(n);
            check("deferred_addr", addr, 20 * k);
            check("deferred_wrap", wrap, 0);
            check("deferred_step", step_active, 20);
        end
        wait_tick(n);
        check("defer_wrap_addr", addr, 4);
        check("defer_wrap_flag", wrap, 1);
        check("defer_new_step", step_active, 2);
        ea = 4;
        for (int k = 0; k < 2; k++) begin
            wait_tick(n);
            ea += 2;
            check("step2_addr", addr, ea);
        end

        // Zero step: frozen address, ticks continue
        en = 1'b0;
        f_step = 8'd0;
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        step();
        check("zero_step_active", step_active, 0);
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_tick(n);
            check("zero_tick_seen", sample_tick, 1);
            check("zero_addr", addr, 0);
            check("zero_wrap", wrap, 0);
        end
        f_step = 8'd10;
        wait_tick(n);
        check("zero_resume_addr", addr, 10);
        check("zero_resume_step", step_active, 10);

        // sync_clr coincident with a tick at addr 77
        f_step = 8'd7;
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        for (int k = 0; k < 11; k++) wait_tick(n);
        check("pre_clr_addr", addr, 77);
        repeat (3) step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check("coinc_addr", addr, 0);
        check("coinc_tick", sample_tick, 0);
        check("coinc_wrap", wrap, 0);
        wait_tick(n);
        check("coinc_latency", n, 4);
        check("coinc_next_addr", addr, 7);

        // Enable dropped at cnt=2
        step();
        step();
        en = 1'b0;
        f_step = 8'd5;
        step();
        check("gate_tick", sample_tick, 0);
        check("gate_addr", addr, 7);
        check("gate_step", step_active, 5);
        for (int k = 0; k < 3; k++) begin
            step();
            check("gate_hold_tick", sample_tick, 0);
        end
        en = 1'b1;
        wait_tick(n);
        check("gate_latency", n, 4);
        check("gate_addr_after", addr, 12);
        check("gate_step_after", step_active, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phase_address_gen.md
Name: phase_address_gen

Overview:
- Downstream of the frequency-control stage: consumes the 8-bit f_step and produces the 8-bit sample address for the 256-point waveform table.
- A clock divider derives the sample tick from the 50 MHz system clock (default /2000 = 40 us).
- A phase accumulator advances by the active step on each tick.
- Step changes are applied only at a period boundary (address wrap), so the output waveform never shows a mid-period frequency glitch.

Parameters:
- DIV, 2000, system-clock cycles per sample tick (>=2).
- CW, 11, divider counter width; must satisfy 2^CW >= DIV.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; low freezes the generator.
- sync_clr  input  1  synchronous restart of phase and divider.
- f_step  input  8  requested phase increment from the frequency-control stage.
- addr  output  8  waveform table address (registered).
- sample_tick  output  1  one-cycle pulse; high in the cycle addr takes a new value.
- wrap  output  1  one-cycle pulse; high in the cycle addr wraps (period start).
- step_active  output  8  increment currently in use (registered).

Behaviour:
- Reset (async, rst=1): cnt=0, addr=0, sample_tick=0, wrap=0, step_active=1. All remain at these values while rst is held.
- Divider:
  - cnt counts 0..DIV-1 while en=1.
  - A tick occurs at an edge where en=1 and cnt==DIV-1; cnt returns to 0 at that edge.
  - While en=0: cnt is held at 0, no ticks, addr is held, and step_active <= f_step every cycle.
  - First tick after en rises comes DIV cycles later.
- Effective step: eff = (step_active==0) ? f_step : step_active.
- On a tick:
  - sum = addr + eff (9-bit); addr <= sum[7:0] (mod 256).
  - sample_tick <= 1.
  - wrap <= sum[8].
  - If sum[8]==1 or step_active==0, then step_active <= f_step; otherwise step_active is unchanged.
- Not a tick: sample_tick <= 0, wrap <= 0.
- Latency: addr, sample_tick and wrap all update on the same edge as the tick. No combinational path exists from f_step to addr.
- f_step changes mid-period are deferred until the wrap tick; the wrap tick itself still uses the old step.
- f_step==0 (step_active==0): addr stays frozen and ticks continue (sample_tick pulses, wrap never asserts). The next tick with nonzero f_step adds it and loads it immediately.
- sync_clr=1 (highest synchronous priority, also over a coincident tick):
  - cnt <= 0, addr <= 0, sample_tick <= 0, wrap <= 0, step_active <= f_step.
  - Active regardless of en.
- Wrap-around: addr 255 with eff=1 goes to 0 with wrap=1. The address sequence has no forced stop at 0; e.g. addr 250 with eff=20 goes to 14.
- Reset mid-operation: all state returns immediately to reset values. After release, behaviour restarts as from power-up.

Test Plan:
- Reset: assert rst mid-count with addr=0x37 -> addr, sample_tick, wrap go to 0 asynchronously; step_active=1; first tick after release and en=1 comes DIV cycles later.
- Basic sweep (DIV=4, f_step=1, en=1): addr increments every 4 cycles with sample_tick each time; after 256 ticks (1024 cycles) addr goes 255->0 with wrap=1 for exactly one cycle.
- Deferred step change (DIV=4, step_active=20): f_step->2 while addr=100 -> sequence 120,140,...,240, then 4 with wrap=1 (step 20 still used), then 6,8,... (step 2).
- Zero step: en=0 with f_step=0, then en=1 -> addr frozen at 0, sample_tick pulses, wrap=0; set f_step=10 -> next tick addr=10 and step_active=10.
- sync_clr coincident with tick at addr=77 -> addr=0, sample_tick=0, wrap=0, cnt=0; next tick comes DIV cycles later.
- Enable gating: drop en at cnt=2 with DIV=4 -> no tick, addr held, cnt=0; raise en -> tick exactly 4 cycles later using the f_step value sampled while en was low.
